// File: rtl/tti_tx_sequencer.sv
// TTI TX response sequencer: pops a descriptor, then streams its data words
// little-endian as bytes to the target bus FSM, draining leftovers on abort.
module tti_tx_sequencer #(
    parameter int unsigned TxDescDataWidth = 32,
    parameter int unsigned TxDataDataWidth = 32,
    parameter int unsigned LenWidth        = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       tx_desc_valid_i,
    output logic                       tx_desc_ready_o,
    input  logic [TxDescDataWidth-1:0] tx_desc_data_i,
    input  logic                       tx_data_valid_i,
    output logic                       tx_data_ready_o,
    input  logic [TxDataDataWidth-1:0] tx_data_data_i,
    output logic                       byte_valid_o,
    input  logic                       byte_ready_i,
    output logic [7:0]                 byte_data_o,
    output logic                       byte_last_o,
    input  logic                       xfer_abort_i,
    output logic                       busy_o,
    output logic                       desc_done_o,
    output logic                       desc_aborted_o
);

    typedef enum logic [1:0] {StIdle, StFetch, StSend, StDrain} state_e;

    localparam logic [LenWidth-1:0] LenOne  = LenWidth'(1);
    localparam logic [LenWidth-2:0] WordOne = (LenWidth - 1)'(1);

    state_e                     state_q, state_d;
    logic [LenWidth-1:0]        remaining_q, remaining_d;
    logic [LenWidth-2:0]        words_left_q, words_left_d;
    logic [1:0]                 byte_idx_q, byte_idx_d;
    logic [TxDataDataWidth-1:0] shift_q, shift_d;
    logic                       done_q, done_d;
    logic                       aborted_q, aborted_d;

    logic [LenWidth-1:0] desc_len;
    logic [LenWidth:0]   desc_len_rnd;
    logic [LenWidth-2:0] desc_words;
    logic                last_byte;
    logic                unused_desc_bits;

    assign desc_len         = tx_desc_data_i[LenWidth-1:0];
    assign desc_len_rnd     = {1'b0, desc_len} + (LenWidth + 1)'(3);
    assign desc_words       = desc_len_rnd[LenWidth:2];
    assign unused_desc_bits = ^tx_desc_data_i[TxDescDataWidth-1:LenWidth];
    assign last_byte        = (remaining_q == LenOne);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            remaining_q  <= '0;
            words_left_q <= '0;
            byte_idx_q   <= '0;
            shift_q      <= '0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            words_left_q <= words_left_d;
            byte_idx_q   <= byte_idx_d;
            shift_q      <= shift_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        words_left_d = words_left_q;
        byte_idx_d   = byte_idx_q;
        shift_d      = shift_q;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tx_desc_valid_i) begin
                    remaining_d  = desc_len;
                    words_left_d = desc_words;
                    byte_idx_d   = '0;
                    if (desc_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StFetch: begin
                if (tx_data_valid_i) begin
                    shift_d      = tx_data_data_i;
                    words_left_d = words_left_q - WordOne;
                    byte_idx_d   = '0;
                    state_d      = StSend;
                end
                // A word popped in the abort cycle already counts as consumed.
                if (xfer_abort_i) begin
                    if (words_left_d != '0) begin
                        state_d = StDrain;
                    end else begin
                        aborted_d = 1'b1;
                        state_d   = StIdle;
                    end
                end
            end
            StSend: begin
                if (xfer_abort_i) begin
                    if (byte_ready_i && last_byte) begin
                        remaining_d = remaining_q - LenOne;
                        done_d      = 1'b1;
                        state_d     = StIdle;
                    end else if (words_left_q != '0) begin
                        state_d = StDrain;
                    end else begin
                        aborted_d = 1'b1;
                        state_d   = StIdle;
                    end
                end else if (byte_ready_i) begin
                    shift_d     = shift_q >> 8;
                    remaining_d = remaining_q - LenOne;
                    byte_idx_d  = byte_idx_q + 2'd1;
                    if (last_byte) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else if (byte_idx_q == 2'd3) begin
                        state_d = StFetch;
                    end
                end
            end
            StDrain: begin
                if (tx_data_valid_i) begin
                    words_left_d = words_left_q - WordOne;
                    if (words_left_q == WordOne) begin
                        aborted_d = 1'b1;
                        state_d   = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Gated by reset so every output reads 0 while reset is held.
    assign tx_desc_ready_o = rst_ni && (state_q == StIdle);
    assign tx_data_ready_o = (state_q == StFetch) || (state_q == StDrain);
    assign byte_valid_o    = (state_q == StSend);
    assign byte_data_o     = shift_q[7:0];
    assign byte_last_o     = (state_q == StSend) && last_byte;
    assign busy_o          = (state_q != StIdle);
    assign desc_done_o     = done_q;
    assign desc_aborted_o  = aborted_q;

endmodule

// File: tb/tb_tti_tx_sequencer.sv
// Scoreboard bench for tti_tx_sequencer: bench-side queues model the TTI
// descriptor/data FIFOs, expected bytes are queued when a descriptor is pushed.
module tb_tti_tx_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        tx_desc_valid_i, tx_desc_ready_o;
    logic [31:0] tx_desc_data_i;
    logic        tx_data_valid_i, tx_data_ready_o;
    logic [31:0] tx_data_data_i;
    logic        byte_valid_o, byte_ready_i, byte_last_o;
    logic [7:0]  byte_data_o;
    logic        xfer_abort_i, busy_o, desc_done_o, desc_aborted_o;

    tti_tx_sequencer dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .tx_desc_valid_i(tx_desc_valid_i),
        .tx_desc_ready_o(tx_desc_ready_o),
        .tx_desc_data_i (tx_desc_data_i),
        .tx_data_valid_i(tx_data_valid_i),
        .tx_data_ready_o(tx_data_ready_o),
        .tx_data_data_i (tx_data_data_i),
        .byte_valid_o   (byte_valid_o),
        .byte_ready_i   (byte_ready_i),
        .byte_data_o    (byte_data_o),
        .byte_last_o    (byte_last_o),
        .xfer_abort_i   (xfer_abort_i),
        .busy_o         (busy_o),
        .desc_done_o    (desc_done_o),
        .desc_aborted_o (desc_aborted_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    logic [31:0] desc_fifo[$];
    logic [31:0] data_fifo[$];
    logic [8:0]  exp_q[$];  // {last, byte}

    bit   ready_toggle = 1'b0;
    bit   abort_now    = 1'b0;
    bit   data_hold    = 1'b0;
    bit   stalled_prev = 1'b0;
    logic [7:0] stalled_byte;

    int cyc = 0;
    int desc_pops, data_pops, done_cnt, abort_cnt, byte_cnt, valid_seen, busy_cnt, stall_checks;
    int desc_pop_cyc, first_valid_cyc, done_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_stats();
        desc_pops = 0; data_pops = 0; done_cnt = 0; abort_cnt = 0; byte_cnt = 0;
        valid_seen = 0; busy_cnt = 0; stall_checks = 0;
        desc_pop_cyc = -1; first_valid_cyc = -1; done_cyc = -1;
    endtask

    task automatic push_desc(input int len, input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] w[4];
        logic [31:0] word;
        w = '{w0, w1, w2, w3};
        desc_fifo.push_back({16'hBEEF, 16'(len)});
        for (int i = 0; i < (len + 3) / 4; i++) data_fifo.push_back(w[i]);
        for (int i = 0; i < len; i++) begin
            word = w[i / 4] >> (8 * (i % 4));
            exp_q.push_back({(i == len - 1), word[7:0]});
        end
    endtask

    // One clock: drive inputs at the falling edge, then account for the
    // handshakes that the next rising edge will complete.
    task automatic cycle();
        logic [8:0] e;
        bit         count_byte;
        @(negedge clk_i);
        cyc++;
        if (stalled_prev) begin
            stall_checks++;
            check("hold_data", {24'b0, byte_data_o}, {24'b0, stalled_byte});
            check("hold_valid", {31'b0, byte_valid_o}, 32'd1);
        end
        if (desc_done_o) begin done_cnt++; done_cyc = cyc; end
        if (desc_aborted_o) abort_cnt++;
        if (busy_o) busy_cnt++;
        if (byte_valid_o) begin
            valid_seen++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        tx_desc_valid_i = (desc_fifo.size() > 0);
        tx_desc_data_i  = tx_desc_valid_i ? desc_fifo[0] : 32'h0;
        tx_data_valid_i = (data_fifo.size() > 0) && !data_hold;
        tx_data_data_i  = tx_data_valid_i ? data_fifo[0] : 32'h0;
        byte_ready_i    = ready_toggle ? ~byte_ready_i : 1'b1;
        xfer_abort_i    = abort_now;
        if (tx_desc_valid_i && tx_desc_ready_o) begin
            void'(desc_fifo.pop_front());
            desc_pops++;
            desc_pop_cyc = cyc;
        end
        if (tx_data_valid_i && tx_data_ready_o) begin
            void'(data_fifo.pop_front());
            data_pops++;
        end
        // A byte taken in an abort cycle only counts if it is the final one.
        count_byte = byte_valid_o && byte_ready_i &&
                     !(xfer_abort_i && !(exp_q.size() > 0 && exp_q[0][8]));
        if (count_byte) begin
            byte_cnt++;
            if (exp_q.size() == 0) begin
                check("byte_unexpected", {23'b0, byte_last_o, byte_data_o}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("byte", {23'b0, byte_last_o, byte_data_o}, {23'b0, e});
            end
        end
        stalled_prev = byte_valid_o && !byte_ready_i && rst_ni;
        stalled_byte = byte_data_o;
    endtask

    task automatic wait_for(input int done_t, input int abort_t);
        for (int i = 0; i < 200; i++) begin
            if (done_cnt >= done_t && abort_cnt >= abort_t) break;
            cycle();
        end
    endtask

    task automatic wait_bytes(input int n);
        for (int i = 0; i < 200; i++) begin
            if (byte_cnt >= n) break;
            cycle();
        end
        check("byte_wait", byte_cnt, n);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {25'b0, tx_desc_ready_o, tx_data_ready_o, byte_valid_o, byte_last_o,
                    busy_o, desc_done_o, desc_aborted_o}, 32'h0);
    endtask

    initial begin
        tx_desc_valid_i = 1'b0; tx_desc_data_i = '0; tx_data_valid_i = 1'b0;
        tx_data_data_i = '0; byte_ready_i = 1'b1; xfer_abort_i = 1'b0;
        reset_stats();
        repeat (3) cycle();
        check_all_zero("reset_outputs");
        check("reset_byte_data", {24'b0, byte_data_o}, 32'h0);
        rst_ni = 1'b1;
        #1;
        check("post_reset_desc_ready", {31'b0, tx_desc_ready_o}, 32'd1);
        check("post_reset_busy", {31'b0, busy_o}, 32'd0);

        // len=6 across two words; high bytes of the second word are dropped
        reset_stats();
        push_desc(6, 32'h44332211, 32'hAABB6655, 32'h0, 32'h0);
        wait_for(1, 0);
        repeat (3) cycle();
        check("t1_done", done_cnt, 1);
        check("t1_pops", data_pops, 2);
        check("t1_bytes", byte_cnt, 6);
        check("t1_exp_left", exp_q.size(), 0);
        check("t1_latency", first_valid_cyc - desc_pop_cyc, 2);

        // zero-length descriptor
        reset_stats();
        push_desc(0, 32'h0, 32'h0, 32'h0, 32'h0);
        wait_for(1, 0);
        repeat (2) cycle();
        check("t2_done", done_cnt, 1);
        check("t2_pops", data_pops, 0);
        check("t2_busy", busy_cnt, 0);
        check("t2_done_latency", done_cyc - desc_pop_cyc, 1);

        // back-pressure toggling every cycle
        reset_stats();
        ready_toggle = 1'b1;
        push_desc(12, 32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h0);
        wait_for(1, 0);
        ready_toggle = 1'b0;
        repeat (3) cycle();
        check("t3_done", done_cnt, 1);
        check("t3_bytes", byte_cnt, 12);
        check("t3_pops", data_pops, 3);
        check("t3_exp_left", exp_q.size(), 0);
        check("t3_stalls_seen", (stall_checks > 0), 1);

        // abort after 5 bytes of 16: two unread words must be drained
        reset_stats();
        push_desc(16, 32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C);
        wait_bytes(5);
        abort_now = 1'b1;
        cycle();
        abort_now = 1'b0;
        exp_q.delete();
        valid_seen = 0;
        wait_for(0, 1);
        repeat (3) cycle();
        check("t4_aborted", abort_cnt, 1);
        check("t4_done", done_cnt, 0);
        check("t4_pops", data_pops, 4);
        check("t4_bytes", byte_cnt, 5);
        check("t4_no_valid", valid_seen, 0);
        reset_stats();
        push_desc(1, 32'hFFFFFFA5, 32'h0, 32'h0, 32'h0);
        wait_for(1, 0);
        repeat (2) cycle();
        check("t4_next_bytes", byte_cnt, 1);
        check("t4_next_exp_left", exp_q.size(), 0);
        check("t4_next_pops", data_pops, 1);

        // abort coinciding with the final byte handshake
        reset_stats();
        push_desc(3, 32'h00C3C2C1, 32'h0, 32'h0, 32'h0);
        wait_bytes(2);
        abort_now = 1'b1;
        cycle();
        abort_now = 1'b0;
        repeat (4) cycle();
        check("t5_done", done_cnt, 1);
        check("t5_aborted", abort_cnt, 0);
        check("t5_bytes", byte_cnt, 3);
        check("t5_pops", data_pops, 1);

        // data queue empty after the descriptor pop, then reset mid-send
        reset_stats();
        data_hold = 1'b1;
        push_desc(8, 32'h23222120, 32'h27262524, 32'h0, 32'h0);
        for (int i = 0; i < 20 && desc_pops == 0; i++) cycle();
        repeat (10) cycle();
        check("t6_no_valid", valid_seen, 0);
        check("t6_no_pop", data_pops, 0);
        check("t6_waiting", {30'b0, busy_o, tx_data_ready_o}, 32'd3);
        data_hold = 1'b0;
        wait_bytes(2);
        check("t6_in_send", {31'b0, byte_valid_o}, 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check_all_zero("t6_reset_outputs");
        repeat (3) cycle();
        exp_q.delete();
        rst_ni = 1'b1;
        #1;
        check("t6_desc_ready", {30'b0, tx_desc_ready_o, busy_o}, 32'd2);
        repeat (5) cycle();
        check("t6_pops_after", data_pops, 1);
        check("t6_no_pulse", done_cnt + abort_cnt, 0);
        check("t6_no_valid_after", byte_valid_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
